// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types for the hazard/forwarding controller.
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_WB = 2'd1, FWD_MEM = 2'd2} fwd_sel_e;
  typedef enum logic [1:0] {RUN, MEM_WAIT, MC_WAIT} ctrl_state_e;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/forward_sel.sv
// forward_sel: E-stage operand bypass select for one source register (M beats W).
module forward_sel
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output fwd_sel_e          sel
);
  localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);
  always_comb
    sel = (reg_write_m && rd_m != ZERO && rd_m == rs) ? FWD_MEM :
          (reg_write_w && rd_w != ZERO && rd_w == rs) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage stall/flush/forwarding sequencer with multi-cycle unit start handshake.
// Define HAZARD_PERF_EN to add stall/flush performance counters.
module hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
`ifdef HAZARD_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              load_e,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              pc_src_e,
  input  logic              mc_valid_e,
  input  logic              mc_done,
  input  logic              dmem_req_m,
  input  logic              dmem_ready,
  output logic              mc_start,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e
`ifdef HAZARD_PERF_EN
  , output logic [PERF_W-1:0] perf_stall_cnt
  , output logic [PERF_W-1:0] perf_flush_cnt
`endif
);
  localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);
  ctrl_state_e state_q, state_d;
  logic mc_issued_q, mc_issued_d, mc_held_q, mc_held_d;
  logic mem_busy, mc_ready, mc_busy, load_use, redirect, lu_stall;
  fwd_sel_e sel_a, sel_b;

  forward_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs(rs1_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .sel(sel_a)
  );
  forward_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs(rs2_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .sel(sel_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      mc_issued_q <= 1'b0;
      mc_held_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mc_issued_q <= mc_issued_d;
      mc_held_q   <= mc_held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      state_d = mem_busy ? MEM_WAIT : mc_busy ? MC_WAIT : RUN;
      MEM_WAIT: state_d = dmem_ready ? (mc_busy ? MC_WAIT : RUN) : MEM_WAIT;
      MC_WAIT:  state_d = mem_busy ? MEM_WAIT : mc_busy ? MC_WAIT : RUN;
      default:  state_d = RUN;
    endcase
  end

  // A result finished under a memory stall stays parked in the unit until E advances.
  always_comb begin
    mem_busy    = dmem_req_m & ~dmem_ready;
    mc_ready    = mc_done | mc_held_q;
    mc_busy     = mc_valid_e & ~mc_ready;
    load_use    = load_e & (rd_e != ZERO) & ((rd_e == rs1_d) | (rd_e == rs2_d));
    redirect    = ~rst & ~mem_busy & ~mc_busy & pc_src_e;
    lu_stall    = ~rst & ~mem_busy & ~mc_busy & ~pc_src_e & load_use;
    mc_start    = ~rst & mc_valid_e & ~mc_issued_q & ~mc_held_q & ~mem_busy;
    stall_m     = ~rst & mem_busy;
    flush_w     = ~rst & mem_busy;
    stall_e     = ~rst & (mem_busy | mc_busy);
    flush_m     = ~rst & ~mem_busy & mc_busy;
    stall_f     = stall_e | lu_stall;
    stall_d     = stall_e | lu_stall;
    flush_d     = redirect;
    flush_e     = redirect | lu_stall;
    fwd_a_e     = rst ? FWD_RF : sel_a;
    fwd_b_e     = rst ? FWD_RF : sel_b;
    mc_issued_d = mc_done ? 1'b0 : (mc_start | mc_issued_q);
    mc_held_d   = (mc_done & mem_busy) | (mc_held_q & stall_e);
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + PERF_W'(stall_f);
    flush_cnt_d = flush_cnt_q + PERF_W'(flush_e);
  end
  always_ff @(posedge clk) begin
    stall_cnt_q <= rst ? '0 : stall_cnt_d;
    flush_cnt_q <= rst ? '0 : flush_cnt_d;
  end
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + randomized check of hazard_ctrl against a rule-level model.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic load_e, reg_write_m, reg_write_w, pc_src_e, mc_valid_e, mc_done, dmem_req_m, dmem_ready;
  logic mc_start, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w;
  logic [1:0] fwd_a_e, fwd_b_e;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int n_tests = 0, n_fail = 0;
  bit m_issued = 0, m_held = 0, hold_e = 0, hold_m = 0;
  int unsigned m_scnt = 0, m_fcnt = 0;
  int n_start = 0, n_stall_e = 0, n_stall_m = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .load_e(load_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .pc_src_e(pc_src_e), .mc_valid_e(mc_valid_e), .mc_done(mc_done),
    .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
    .mc_start(mc_start), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'd2;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'd1;
    return 2'd0;
  endfunction

  task automatic idle();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {load_e, reg_write_m, reg_write_w, pc_src_e, mc_valid_e, mc_done, dmem_req_m, dmem_ready} = '0;
  endtask

  task automatic zero_obs();
    n_start = 0; n_stall_e = 0; n_stall_m = 0;
  endtask

  // One cycle: check at negedge against the model, then advance the model.
  task automatic tick();
    logic [8:0] exp_ctl;
    int cause;
    bit mb, lu, start;
    @(negedge clk);
    mb = dmem_req_m && !dmem_ready;
    lu = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    start = !rst && mc_valid_e && !m_issued && !m_held && !mb;
    if (rst) cause = 0;
    else if (mb) cause = 1;
    else if (mc_valid_e && !(mc_done || m_held)) cause = 2;
    else if (pc_src_e) cause = 3;
    else if (lu) cause = 4;
    else cause = 0;
    case (cause)
      1: exp_ctl = 9'b0_1111_0001;
      2: exp_ctl = 9'b0_1110_0010;
      3: exp_ctl = 9'b0_0000_1100;
      4: exp_ctl = 9'b0_1100_0100;
      default: exp_ctl = '0;
    endcase
    exp_ctl[8] = start;
    check("ctl", 32'({mc_start, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w}),
          32'(exp_ctl));
    check("fwd_a", 32'(fwd_a_e), rst ? 32'd0 : 32'(ref_fwd(rs1_e)));
    check("fwd_b", 32'(fwd_b_e), rst ? 32'd0 : 32'(ref_fwd(rs2_e)));
`ifdef HAZARD_PERF_EN
    check("perf_stall", perf_stall_cnt, m_scnt);
    check("perf_flush", perf_flush_cnt, m_fcnt);
`endif
    n_start += int'(mc_start);
    n_stall_e += int'(stall_e);
    n_stall_m += int'(stall_m);
    if (rst) begin
      m_issued = 0; m_held = 0; m_scnt = 0; m_fcnt = 0; hold_e = 0; hold_m = 0;
    end else begin
      m_held = (mc_done && mb) || (m_held && exp_ctl[5]);
      m_issued = !mc_done && (m_issued || start);
      m_scnt += int'(exp_ctl[7]);
      m_fcnt += int'(exp_ctl[2]);
      hold_e = exp_ctl[5];
      hold_m = exp_ctl[4];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    bit mb, start;
    rst = ($urandom_range(99) == 0);
    rs1_d = 5'($urandom_range(3));
    rs2_d = 5'($urandom_range(3));
    if (!hold_e) begin
      rs1_e = 5'($urandom_range(3));
      rs2_e = 5'($urandom_range(3));
      rd_e = 5'($urandom_range(3));
      load_e = ($urandom_range(2) == 0);
      mc_valid_e = ($urandom_range(3) == 0);
      pc_src_e = ($urandom_range(4) == 0);
    end
    if (!hold_m) begin
      rd_m = 5'($urandom_range(3));
      reg_write_m = ($urandom_range(1) == 0);
      dmem_req_m = ($urandom_range(2) == 0);
    end
    rd_w = 5'($urandom_range(3));
    reg_write_w = ($urandom_range(1) == 0);
    dmem_ready = ($urandom_range(1) == 0);
    mb = dmem_req_m && !dmem_ready;
    start = !rst && mc_valid_e && !m_issued && !m_held && !mb;
    mc_done = !rst && (m_issued || start) && ($urandom_range(3) == 0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;

    reg_write_m = 1; rd_m = 5; rs1_e = 5; reg_write_w = 1; rd_w = 5;
    tick();
    check("t1_fwd_m_over_w", 32'(fwd_a_e), 32'd2);
    rd_m = 0; rs1_e = 0; rd_w = 0;
    tick();
    check("t1_fwd_x0", 32'(fwd_a_e), 32'd0);
    idle();

    load_e = 1; rd_e = 7; rs2_d = 7;
    tick();
    check("t2_lu", 32'({stall_f, stall_d, flush_e}), 32'h7);
    load_e = 0;
    tick();
    check("t2_lu_one_cycle", 32'({stall_f, stall_d, flush_e}), 32'h0);
    load_e = 1; rd_e = 0; rs2_d = 0;
    tick();
    check("t2_rd0", 32'({stall_f, stall_d, flush_e}), 32'h0);

    rd_e = 7; rs2_d = 7; pc_src_e = 1;
    tick();
    check("t3_redirect", 32'({flush_d, flush_e, stall_f}), 32'h6);
    idle();

    zero_obs();
    mc_valid_e = 1;
    repeat (4) tick();
    mc_done = 1;
    tick();
    check("t4_starts", n_start, 1);
    check("t4_stall_e", n_stall_e, 4);
    idle();
    tick();

    zero_obs();
    mc_valid_e = 1;
    tick();
    dmem_req_m = 1;
    repeat (3) tick();
    dmem_req_m = 0;
    tick();
    mc_done = 1;
    tick();
    check("t5_starts", n_start, 1);
    check("t5_stall_m", n_stall_m, 3);
    idle();
    tick();

    mc_valid_e = 1;
    repeat (2) tick();
    rst = 1;
    tick();
`ifdef HAZARD_PERF_EN
    check("t6_perf_clr", perf_stall_cnt + perf_flush_cnt, 32'd0);
`endif
    rst = 0;
    zero_obs();
    tick();
    check("t6_fresh_start", n_start, 1);
    mc_done = 1;
    tick();
    idle();
    tick();

    repeat (3000) begin
      rand_inputs();
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
